// File: rtl/arbitro_pkg.sv
// Shared definitions for the round-robin register write arbiter:
// FSM encoding, size limits and a ceiling-log2 helper.
package arbitro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam int MAX_N_REQ = 8;

    function automatic int arb_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/arbitro_registro_rr_select.sv
// Combinational round-robin search: first requester at or after ptr_i,
// wrapping ascending through N_REQ entries.
module rr_select #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic             found_o,
    output logic [PTR_W-1:0] idx_o
);

    always_comb begin
        int j;
        j       = 0;
        found_o = 1'b0;
        idx_o   = '0;
        // Scan from the farthest offset down so the nearest hit to ptr_i wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (req_i[j]) begin
                found_o = 1'b1;
                idx_o   = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/arbitro_registro.sv
// Round-robin write arbiter/sequencer owning a shared WIDTH-bit register:
// grant, stage data, pulse write enable, then acknowledge the winner.
module arbitro_registro
    import arbitro_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] dato_in,
    output logic [N_REQ-1:0]       gnt,
    output logic                   we,
    output logic [WIDTH-1:0]       dato_out,
    output logic [N_REQ-1:0]       ack,
    output logic                   busy,
    output logic [WIDTH-1:0]       q
);

    localparam int PTR_W = arb_clog2(N_REQ);

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] winner_q, winner_d;
    logic [WIDTH-1:0] stage_q, stage_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             we_q, we_d;
    logic             busy_q, busy_d;
    logic             found;
    logic [PTR_W-1:0] sel_idx;

    rr_select #(
        .N_REQ(N_REQ),
        .PTR_W(PTR_W)
    ) u_rr_select (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .found_o(found),
        .idx_o  (sel_idx)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        stage_d  = stage_q;
        reg_d    = reg_q;
        gnt_d    = '0;
        ack_d    = '0;
        we_d     = 1'b0;
        busy_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    winner_d = sel_idx;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                stage_d = dato_in[int'(winner_q)*WIDTH +: WIDTH];
                state_d = WRITE;
            end
            WRITE: state_d = ACK;
            ACK: begin
                ptr_d   = (winner_q == PTR_W'(N_REQ - 1)) ? '0 : winner_q + PTR_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (we_q) reg_d = stage_q;

        // Outputs are decoded from the next state so they register in step with it.
        if (state_d != IDLE) begin
            gnt_d[winner_d] = 1'b1;
            busy_d          = 1'b1;
        end
        we_d = (state_d == WRITE);
        if (state_d == ACK) ack_d[winner_d] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            winner_q <= '0;
            stage_q  <= '0;
            reg_q    <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            stage_q  <= stage_d;
            reg_q    <= reg_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign we       = we_q;
    assign busy     = busy_q;
    assign dato_out = stage_q;
    assign q        = reg_q;

endmodule

// File: doc/arbitro_registro.md
# arbitro_registro

Round-robin write arbiter and sequencer for a shared WIDTH-bit register built from positive-edge D flip-flops. Up to N_REQ requesters post a write request with data. The block grants one requester at a time, stages its data, and pulses the register's write enable. It then acknowledges the winner. It sits between the requesting control blocks and the shared register, and is the only block allowed to drive that register's data and enable.

## Interface
- N_REQ, 4: number of requesters (2..8)
- WIDTH, 8: data width of the shared register
- PTR_W, $clog2(N_REQ): width of the round-robin pointer (derived, not overridden)

- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  N_REQ  per-requester write request; requester holds it high until its ack
- dato_in  in  N_REQ*WIDTH  packed request data; requester i occupies bits [i*WIDTH +: WIDTH]
- gnt  out  N_REQ  one-hot grant, high during GRANT, WRITE and ACK for the winner
- we  out  1  write enable to the shared register, one-cycle pulse
- dato_out  out  WIDTH  staged data to the shared register's D inputs
- ack  out  N_REQ  one-hot, one-cycle completion pulse to the winner
- busy  out  1  high in every state except IDLE
- q  out  WIDTH  shared register contents; loaded when we=1

## Operation
- States: IDLE, GRANT, WRITE, ACK. Encoding comes from the package.
- IDLE: if req != 0, select a winner with rr_select, latch its index and go to GRANT. Otherwise stay in IDLE.
- GRANT: gnt[winner]=1. dato_in slice of the winner captured into the staging register at the end of the cycle. Always goes to WRITE.
- WRITE: we=1 and dato_out=staged data. The shared register q loads dato_out on the closing edge. Always goes to ACK.
- ACK: ack[winner]=1. On exit, ptr <= (winner+1) mod N_REQ. Always goes to IDLE.
- Round-robin: the search begins at index ptr and wraps ascending. The first requester with req high wins.
- Requests are sampled only in IDLE.
  - Deasserting req after sampling does not abort; the write completes and ack still pulses.
  - Asserting a new req mid-transaction waits for the next IDLE.
- dato_in of the winner must be stable through GRANT. Changes after GRANT do not affect the written value.
- All outputs are registered; no combinational path from req or dato_in to any output.
- Reset (any time, including mid-transaction):
  - state=IDLE, ptr=0, winner=0, staging=0, q=0, gnt=0, we=0, ack=0, busy=0, dato_out=0.
  - No ack is issued for an interrupted transaction.

## Timing
- req first high in cycle 0 while IDLE: gnt in cycle 1, we in cycle 2, q updated from cycle 3, ack in cycle 3, IDLE in cycle 4.
- Latency from sampled req to ack is 3 cycles; throughput is one write per 4 cycles.
- Re-arbitration happens in IDLE (cycle 4). A requester still holding req after its ack gets the lowest priority because ptr has advanced past it.
- ack and we never coincide. gnt is one-hot or zero in every cycle.
- ptr wraps from N_REQ-1 to 0.

## Structure
- Package arbitro_pkg holds:
  - the state typedef/localparams (IDLE=2'd0, GRANT=2'd1, WRITE=2'd2, ACK=2'd3);
  - a ceiling-log2 helper function;
  - the maximum N_REQ constant (8).
- Sub-module rr_select: combinational. Inputs req and ptr; outputs found and idx (PTR_W). Finds the first set bit at or after ptr, with wrap.
- The top level contains the FSM, winner/ptr registers, staging register and the shared q register. q is a WIDTH-bit bank with enable.

## Test plan
- Reset mid-WRITE with staging=8'hA5: assert rst_n=0 -> all outputs 0, q=8'h00, no ack. After release, IDLE with ptr=0.
- Single requester: req=4'b0100, slice2=8'h3C -> gnt=4'b0100 in cycle 1, we in cycle 2, ack=4'b0100 in cycle 3, q=8'h3C from cycle 3.
- Contention, all four requesters held high continuously: ack order is 0,1,2,3,0, one ack every 4 cycles.
- Wrap: after requester 3 wins, req=4'b1001 -> requester 0 wins next (ptr=0), then requester 3.
- Withdrawal: requester 1 drops req in cycle 1 with slice1=8'h5A -> write still completes, q=8'h5A, ack[1] pulses in cycle 3.
- Data change: slice changes from 8'h11 to 8'hFF in cycle 2 -> q=8'h11.
